// File: rtl/stack_ctl_pkg.sv
// Shared definitions for the register-stack controller: op encodings, default word width
// and the debug-peek FSM state type.
package stack_ctl_pkg;

  localparam int STACK_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } stack_op_e;

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_DONE = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/stack_ctl_if.sv
// CPU/debug side bundle of the stack controller. The master drives ops and peek requests;
// the slave (the controller) returns TOS, depth, flags and peek results.
interface stack_ctl_if
  import stack_ctl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = STACK_WIDTH
);

  stack_op_e        op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] tos;
  logic [DEPTH:0]   depth;
  logic             ovf;
  logic             unf;
  logic             clr_err;
  logic             dbg_req;
  logic [DEPTH-1:0] dbg_idx;
  logic             dbg_ack;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output op, din, clr_err, dbg_req, dbg_idx,
    input  tos, depth, ovf, unf, dbg_ack, dbg_data
  );

  modport slave (
    input  op, din, clr_err, dbg_req, dbg_idx,
    output tos, depth, ovf, unf, dbg_ack, dbg_data
  );

endinterface

// File: rtl/stack_ctl_stack.sv
// Stack storage: 2**DEPTH words with one synchronous write port and one combinational
// read port. Contents are deliberately not reset.
module stack
  import stack_ctl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [DEPTH-1:0] wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [DEPTH-1:0] ra_i,
  output logic [WIDTH-1:0] rd_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/stack_ctl.sv
// Stack sequencing controller: pointer, registered TOS, depth, sticky error flags and a
// debug peek port that borrows the RAM read address whenever the CPU is not popping.
module stack_ctl
  import stack_ctl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = STACK_WIDTH
) (
  input logic        clk,
  input logic        reset,
  stack_ctl_if.slave bus
);

  localparam logic [DEPTH:0]   DEPTH_FULL = (DEPTH + 1)'((2 ** DEPTH) + 1);
  localparam logic [DEPTH:0]   CNT_ONE    = (DEPTH + 1)'(1);
  localparam logic [DEPTH:0]   CNT_ZERO   = (DEPTH + 1)'(0);
  localparam logic [DEPTH-1:0] SP_ONE     = DEPTH'(1);
  localparam logic [DEPTH-1:0] SP_RESET   = {DEPTH{1'b1}};

  stack_op_e        op_s;
  logic [DEPTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [DEPTH:0]   depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_evt_s, unf_evt_s;
  logic [WIDTH-1:0] dbg_data_q, dbg_data_d;
  dbg_state_e       dbg_state_q, dbg_state_d;
  logic             dbg_grant_s, dbg_ack_s;

  logic             ram_we_s;
  logic [DEPTH-1:0] ram_wa_s;
  logic [WIDTH-1:0] ram_wd_s;
  logic [DEPTH-1:0] ram_ra_s;
  logic [WIDTH-1:0] ram_rd_s;

  assign op_s = bus.op;

  stack #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_stack (
    .clk_i (clk),
    .we_i  (ram_we_s),
    .wa_i  (ram_wa_s),
    .wd_i  (ram_wd_s),
    .ra_i  (ram_ra_s),
    .rd_o  (ram_rd_s)
  );

  // RAM port steering: a POP owns the read address, otherwise the debug peek does.
  always_comb begin
    ram_we_s = (op_s == OP_PUSH);
    ram_wa_s = sp_q + SP_ONE;
    ram_wd_s = tos_q;
    if (op_s == OP_POP) begin
      ram_ra_s = sp_q;
    end else begin
      ram_ra_s = sp_q - bus.dbg_idx;
    end
  end

  // Pointer, TOS and depth next state; errors still execute the op, only depth saturates.
  always_comb begin
    sp_d      = sp_q;
    tos_d     = tos_q;
    depth_d   = depth_q;
    ovf_evt_s = 1'b0;
    unf_evt_s = 1'b0;
    case (op_s)
      OP_NOP: begin
        sp_d = sp_q;
      end
      OP_PUSH: begin
        sp_d  = sp_q + SP_ONE;
        tos_d = bus.din;
        if (depth_q == DEPTH_FULL) begin
          ovf_evt_s = 1'b1;
        end else begin
          depth_d = depth_q + CNT_ONE;
        end
      end
      OP_POP: begin
        sp_d  = sp_q - SP_ONE;
        tos_d = ram_rd_s;
        if (depth_q == CNT_ZERO) begin
          unf_evt_s = 1'b1;
        end else begin
          depth_d = depth_q - CNT_ONE;
        end
      end
      OP_REPL: begin
        tos_d = bus.din;
      end
      default: begin
        sp_d = sp_q;
      end
    endcase
  end

  // Sticky flags: a new event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (bus.clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (unf_evt_s) begin
      unf_d = 1'b1;
    end else if (bus.clr_err) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Peek result capture on grant; the read port then addresses sp-dbg_idx.
  always_comb begin
    if (dbg_grant_s) begin
      dbg_data_d = ram_rd_s;
    end else begin
      dbg_data_d = dbg_data_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q       <= SP_RESET;
      tos_q      <= {WIDTH{1'b0}};
      depth_q    <= CNT_ZERO;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dbg_data_q <= {WIDTH{1'b0}};
    end else begin
      sp_q       <= sp_d;
      tos_q      <= tos_d;
      depth_q    <= depth_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Debug FSM state register; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_state_q <= DBG_IDLE;
    end else begin
      dbg_state_q <= dbg_state_d;
    end
  end

  // Debug FSM next state.
  always_comb begin
    dbg_state_d = dbg_state_q;
    case (dbg_state_q)
      DBG_IDLE: begin
        if (dbg_grant_s) begin
          dbg_state_d = DBG_DONE;
        end else begin
          dbg_state_d = DBG_IDLE;
        end
      end
      DBG_DONE: begin
        dbg_state_d = DBG_IDLE;
      end
      default: begin
        dbg_state_d = DBG_IDLE;
      end
    endcase
  end

  // Debug FSM outputs: grant only from IDLE so the ack can never repeat back to back.
  always_comb begin
    dbg_grant_s = 1'b0;
    dbg_ack_s   = 1'b0;
    case (dbg_state_q)
      DBG_IDLE: begin
        dbg_grant_s = bus.dbg_req && (op_s != OP_POP);
      end
      DBG_DONE: begin
        dbg_ack_s = 1'b1;
      end
      default: begin
        dbg_ack_s = 1'b0;
      end
    endcase
  end

  assign bus.tos      = tos_q;
  assign bus.depth    = depth_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.dbg_ack  = dbg_ack_s;
  assign bus.dbg_data = dbg_data_q;

endmodule

// File: tb/tb_stack_ctl.sv
// Directed bench for stack_ctl: a pointer/array stack model checked every cycle, plus
// literal expectations at the points worked out by hand.
module tb_stack_ctl;
  import stack_ctl_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int NENT  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  stack_ctl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  stack_ctl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: RAM image with per-entry "known" flags, since the RAM is never reset.
  logic [WIDTH-1:0] m_mem [NENT];
  bit               m_k   [NENT];
  int               m_sp, m_depth;
  logic [WIDTH-1:0] m_tos, m_data;
  bit               m_tos_k, m_data_k, m_ovf, m_unf, m_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_p
    bit gnt;
    bit oe;
    bit ue;
    int a;
    if (reset) begin
      m_sp = NENT - 1; m_depth = 0; m_tos = '0; m_tos_k = 1'b1;
      m_ovf = 1'b0; m_unf = 1'b0; m_ack = 1'b0; m_data = '0; m_data_k = 1'b1;
    end else begin
      gnt = bus.dbg_req && (bus.op != OP_POP) && !m_ack;
      if (gnt) begin
        a = (m_sp - int'(bus.dbg_idx) + NENT) % NENT;
        m_data = m_mem[a];
        m_data_k = m_k[a];
      end
      m_ack = gnt;
      oe = 1'b0;
      ue = 1'b0;
      case (bus.op)
        OP_PUSH: begin
          a = (m_sp + 1) % NENT;
          m_mem[a] = m_tos; m_k[a] = m_tos_k; m_sp = a;
          m_tos = bus.din; m_tos_k = 1'b1;
          if (m_depth == NENT + 1) oe = 1'b1; else m_depth++;
        end
        OP_POP: begin
          m_tos = m_mem[m_sp]; m_tos_k = m_k[m_sp];
          m_sp = (m_sp + NENT - 1) % NENT;
          if (m_depth == 0) ue = 1'b1; else m_depth--;
        end
        OP_REPL: begin
          m_tos = bus.din; m_tos_k = 1'b1;
        end
        default: ;
      endcase
      m_ovf = oe || (m_ovf && !bus.clr_err);
      m_unf = ue || (m_unf && !bus.clr_err);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_tos_k) chk("m_tos", 32'(bus.tos), 32'(m_tos));
      chk("m_depth", 32'(bus.depth), 32'(m_depth));
      chk("m_ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("m_unf", 32'(bus.unf), 32'(m_unf));
      chk("m_ack", 32'(bus.dbg_ack), 32'(m_ack));
      if (m_data_k) chk("m_dbg_data", 32'(bus.dbg_data), 32'(m_data));
    end
  end

  task automatic step(input stack_op_e o, input logic [WIDTH-1:0] d);
    bus.op  = o;
    bus.din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(OP_NOP, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    bus.op = OP_NOP; bus.din = 16'h0000; bus.clr_err = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_idx = 4'd0;
    do_reset();
    chk_en = 1'b1;
    chk("rst_tos", 32'(bus.tos), 32'h0);
    chk("rst_depth", 32'(bus.depth), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_unf", 32'(bus.unf), 32'd0);
    chk("rst_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rst_dbg_data", 32'(bus.dbg_data), 32'h0);

    // Push three, pop three; the last pop returns the reset TOS written at RAM[0].
    step(OP_PUSH, 16'h1111);
    step(OP_PUSH, 16'h2222);
    step(OP_PUSH, 16'h3333);
    chk("t1_tos3", 32'(bus.tos), 32'h3333);
    chk("t1_depth3", 32'(bus.depth), 32'd3);
    step(OP_POP, 16'h0000);
    chk("t1_tos2", 32'(bus.tos), 32'h2222);
    chk("t1_depth2", 32'(bus.depth), 32'd2);
    step(OP_POP, 16'h0000);
    chk("t1_tos1", 32'(bus.tos), 32'h1111);
    chk("t1_depth1", 32'(bus.depth), 32'd1);
    step(OP_POP, 16'h0000);
    chk("t1_tos0", 32'(bus.tos), 32'h0);
    chk("t1_depth0", 32'(bus.depth), 32'd0);
    chk("t1_unf", 32'(bus.unf), 32'd0);

    // Fill to capacity, then overflow once.
    do_reset();
    for (int i = 1; i <= 17; i++) step(OP_PUSH, 16'(i));
    chk("t2_depth17", 32'(bus.depth), 32'd17);
    chk("t2_tos17", 32'(bus.tos), 32'd17);
    chk("t2_ovf0", 32'(bus.ovf), 32'd0);
    step(OP_PUSH, 16'd18);
    chk("t2_ovf1", 32'(bus.ovf), 32'd1);
    chk("t2_depth_sat", 32'(bus.depth), 32'd17);
    chk("t2_tos18", 32'(bus.tos), 32'd18);
    step(OP_POP, 16'h0000);
    chk("t2_pop_tos", 32'(bus.tos), 32'd17);
    chk("t2_pop_depth", 32'(bus.depth), 32'd16);

    // Underflow and clr_err racing a new underflow.
    do_reset();
    step(OP_POP, 16'h0000);
    chk("t3_unf", 32'(bus.unf), 32'd1);
    chk("t3_depth", 32'(bus.depth), 32'd0);
    bus.clr_err = 1'b1;
    step(OP_POP, 16'h0000);
    chk("t3_clr_vs_evt", 32'(bus.unf), 32'd1);
    step(OP_NOP, 16'h0000);
    chk("t3_clr", 32'(bus.unf), 32'd0);
    bus.clr_err = 1'b0;

    // Peek idx=1 during NOPs, holding the request across the ack for a second grant.
    do_reset();
    step(OP_PUSH, 16'h000A);
    step(OP_PUSH, 16'h000B);
    step(OP_PUSH, 16'h000C);
    bus.dbg_req = 1'b1; bus.dbg_idx = 4'd1;
    step(OP_NOP, 16'h0000);
    chk("t4_ack", 32'(bus.dbg_ack), 32'd1);
    chk("t4_data", 32'(bus.dbg_data), 32'h000A);
    chk("t4_tos", 32'(bus.tos), 32'h000C);
    step(OP_NOP, 16'h0000);
    chk("t4_no_b2b_ack", 32'(bus.dbg_ack), 32'd0);
    step(OP_NOP, 16'h0000);
    chk("t4_reack", 32'(bus.dbg_ack), 32'd1);
    bus.dbg_req = 1'b0;
    step(OP_NOP, 16'h0000);
    chk("t4_ack_low", 32'(bus.dbg_ack), 32'd0);

    // Peek stalled by two POPs; data is the NOS at grant time.
    step(OP_PUSH, 16'h000D);
    step(OP_PUSH, 16'h000E);
    bus.dbg_req = 1'b1; bus.dbg_idx = 4'd0;
    step(OP_POP, 16'h0000);
    chk("t5_stall1", 32'(bus.dbg_ack), 32'd0);
    chk("t5_tos_d", 32'(bus.tos), 32'h000D);
    step(OP_POP, 16'h0000);
    chk("t5_stall2", 32'(bus.dbg_ack), 32'd0);
    step(OP_NOP, 16'h0000);
    chk("t5_ack", 32'(bus.dbg_ack), 32'd1);
    chk("t5_data", 32'(bus.dbg_data), 32'h000B);
    chk("t5_tos_c", 32'(bus.tos), 32'h000C);
    bus.dbg_req = 1'b0;
    step(OP_REPL, 16'h1234);
    chk("t5_repl_tos", 32'(bus.tos), 32'h1234);
    chk("t5_repl_depth", 32'(bus.depth), 32'd3);

    // Reset with a pending peek, a sticky flag and a PUSH in the same cycle.
    do_reset();
    step(OP_POP, 16'h0000);
    step(OP_PUSH, 16'h0055);
    step(OP_PUSH, 16'h0066);
    bus.dbg_req = 1'b1;
    step(OP_POP, 16'h0000);
    chk("t6_pending", 32'(bus.dbg_ack), 32'd0);
    chk("t6_unf_set", 32'(bus.unf), 32'd1);
    reset = 1'b1;
    step(OP_PUSH, 16'h0077);
    reset = 1'b0;
    chk("t6_ack", 32'(bus.dbg_ack), 32'd0);
    chk("t6_tos", 32'(bus.tos), 32'h0);
    chk("t6_depth", 32'(bus.depth), 32'd0);
    chk("t6_unf", 32'(bus.unf), 32'd0);
    chk("t6_ovf", 32'(bus.ovf), 32'd0);
    bus.dbg_req = 1'b0;
    step(OP_NOP, 16'h0000);
    chk("t6_no_late_ack", 32'(bus.dbg_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
